// File: rtl/ysyx_22051013_ifid_buf_pkg.sv
// Shared widths, NOP encoding, FSM states and beat payload for the IF->ID buffer.
// Optional commit trace in the top is enabled with YSYX_22051013_IFID_TRACE_EN.
package ysyx_22051013_ifid_buf_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } beat_t;

endpackage

// File: rtl/ysyx_22051013_ifid_entry.sv
// One {pc, inst} storage slot with load enable; used for the head and skid entries.
module ysyx_22051013_ifid_entry
    import ysyx_22051013_ifid_buf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ld,
    input  beat_t d,
    output beat_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '{pc: '0, inst: NOP_INST};
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_22051013_ifid_buf.sv
// IF->ID pipeline buffer: 2-entry skid so if_ready_o is a flop with no ID->IF combinational path.
// Define YSYX_22051013_IFID_TRACE_EN to report every popped beat through ifid_commit().
module ysyx_22051013_ifid_buf
    import ysyx_22051013_ifid_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              if_valid_i,
    input  logic [PC_W-1:0]   if_pc_i,
    input  logic [INST_W-1:0] if_inst_i,
    output logic              if_ready_o,
    output logic              id_valid_o,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i
);

    state_e            state_q;
    state_e            state_d;
    logic              ready_q;
    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic              push;
    logic              pop;
    logic              head_ld;
    logic              skid_ld;
    logic              head_from_skid;
    beat_t             in_beat;
    beat_t             head_d;
    beat_t             head_q;
    beat_t             skid_q;
    beat_t             head_next;

    assign in_beat = '{pc: if_pc_i, inst: if_inst_i};
    assign push    = if_valid_i & ready_q;
    assign pop     = valid_q & id_ready_i;
    assign head_d  = head_from_skid ? skid_q : in_beat;

    // Next-state and entry load decode; flush overrides every other event.
    always_comb begin
        state_d        = state_q;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        head_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_ld = 1'b1;
                    end else if (push) begin
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        head_ld        = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign head_next = head_ld ? head_d : head_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
            valid_q <= (state_d != ST_EMPTY);
            inst_q  <= (state_d != ST_EMPTY) ? head_next.inst : NOP_INST;
        end
    end

    ysyx_22051013_ifid_entry u_head (
        .clk (clk),
        .rst (rst),
        .ld  (head_ld),
        .d   (head_d),
        .q   (head_q)
    );

    ysyx_22051013_ifid_entry u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (in_beat),
        .q   (skid_q)
    );

    assign if_ready_o = ready_q;
    assign id_valid_o = valid_q;
    assign id_pc_o    = head_q.pc;
    assign id_inst_o  = inst_q;

`ifdef YSYX_22051013_IFID_TRACE_EN
    function automatic void ifid_commit(input longint pc, input int inst);
        $display("ifid_commit pc=%h inst=%h", pc, inst);
    endfunction

    // Report the head beat on every pop; decode owns it even if a flush lands the same cycle.
    always @(posedge clk) begin
        if (rst && pop) begin
            ifid_commit(longint'(head_q.pc), int'(head_q.inst));
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22051013_ifid_buf.sv
// Self-checking bench for ysyx_22051013_ifid_buf: directed vector table, async reset case, random run vs queue model.
module tb_ysyx_22051013_ifid_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_valid_i;
    logic [63:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_ready_o;
    logic        id_valid_o;
    logic [63:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22051013_ifid_buf dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_ready_i (id_ready_i)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } mbeat_t;

    typedef struct {
        logic        f;
        logic        v;
        logic [63:0] pc;
        logic        r;
        logic        ev;
        logic [63:0] epc;
        logic        erdy;
    } vec_t;

    // Reference model: a FIFO of accepted beats, capacity two.
    mbeat_t      mq[$];
    logic [63:0] m_head_pc;
    logic        m_ready;

    function automatic logic [31:0] inst_of(input logic [63:0] p);
        return p[31:0] ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mk(input logic f, input logic v, input logic [63:0] pc, input logic r,
                                input logic ev, input logic [63:0] epc, input logic erdy);
        vec_t t;
        t.f = f; t.v = v; t.pc = pc; t.r = r; t.ev = ev; t.epc = epc; t.erdy = erdy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head_pc = '0;
        m_ready   = 1'b1;
    endtask

    // Drive one cycle of inputs at negedge, advance the model across posedge, settle 1 time unit.
    task automatic step(input logic f, input logic v, input logic [63:0] p, input logic r);
        logic   push;
        logic   pop;
        mbeat_t tmp;
        @(negedge clk);
        flush_i    = f;
        if_valid_i = v;
        if_pc_i    = p;
        if_inst_i  = inst_of(p);
        id_ready_i = r;
        push = v && m_ready;
        pop  = (mq.size() > 0) && r;
        @(posedge clk);
        if (pop) tmp = mq.pop_front();
        if (f) mq.delete();
        else if (push) mq.push_back('{pc: p, inst: inst_of(p)});
        m_ready = (mq.size() < 2);
        if (mq.size() > 0) m_head_pc = mq[0].pc;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 64'(id_valid_o), 64'(mq.size() > 0));
        chk({tag, "_pc"},    id_pc_o, m_head_pc);
        chk({tag, "_inst"},  64'(id_inst_o), 64'((mq.size() > 0) ? mq[0].inst : NOP));
        chk({tag, "_ready"}, 64'(if_ready_o), 64'(m_ready));
    endtask

    localparam logic [63:0] A = 64'h8000_0000;
    localparam logic [63:0] B = 64'h8000_0004;
    localparam logic [63:0] C = 64'h8000_0008;
    localparam logic [63:0] D = 64'h8000_000C;
    localparam logic [63:0] E = 64'h8000_0040;
    localparam logic [63:0] W = 64'h8000_0100;

    vec_t vt[16];

    initial begin
        rst        = 1'b0;
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        if_pc_i    = '0;
        if_inst_i  = '0;
        id_ready_i = 1'b0;
        model_reset();

        // streaming with decode always ready
        vt[0]  = mk(0, 1, A, 1,  1, A, 1);
        vt[1]  = mk(0, 1, B, 1,  1, B, 1);
        vt[2]  = mk(0, 1, C, 1,  1, C, 1);
        vt[3]  = mk(0, 1, D, 1,  1, D, 1);
        vt[4]  = mk(0, 0, 0, 1,  0, D, 1);
        // fill both entries under backpressure, then drain
        vt[5]  = mk(0, 1, A, 0,  1, A, 1);
        vt[6]  = mk(0, 1, B, 0,  1, A, 0);
        vt[7]  = mk(0, 1, E, 0,  1, A, 0);
        vt[8]  = mk(0, 0, 0, 1,  1, B, 1);
        vt[9]  = mk(0, 0, 0, 1,  0, B, 1);
        // flush in TWO with a same-cycle wrong-path beat
        vt[10] = mk(0, 1, A, 0,  1, A, 1);
        vt[11] = mk(0, 1, B, 0,  1, A, 0);
        vt[12] = mk(1, 1, W, 0,  0, A, 1);
        vt[13] = mk(0, 0, 0, 1,  0, A, 1);
        // flush coinciding with a pop in ONE
        vt[14] = mk(0, 1, C, 0,  1, C, 1);
        vt[15] = mk(1, 0, 0, 1,  0, C, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(id_valid_o), 64'(0));
        chk("rst_pc",    id_pc_o, 64'(0));
        chk("rst_inst",  64'(id_inst_o), 64'(NOP));
        chk("rst_ready", 64'(if_ready_o), 64'(1));

        for (int i = 0; i < 16; i++) begin
            step(vt[i].f, vt[i].v, vt[i].pc, vt[i].r);
            chk($sformatf("vec%0d_valid", i), 64'(id_valid_o), 64'(vt[i].ev));
            chk($sformatf("vec%0d_pc", i),    id_pc_o, vt[i].epc);
            chk($sformatf("vec%0d_inst", i),  64'(id_inst_o), 64'(vt[i].ev ? inst_of(vt[i].epc) : NOP));
            chk($sformatf("vec%0d_ready", i), 64'(if_ready_o), 64'(vt[i].erdy));
            check_model($sformatf("vec%0d_model", i));
        end

        // asynchronous reset between edges while holding one entry
        step(0, 1, E, 0);
        chk("pre_arst_valid", 64'(id_valid_o), 64'(1));
        @(negedge clk);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        id_ready_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(id_valid_o), 64'(0));
        chk("arst_inst",  64'(id_inst_o), 64'(NOP));
        chk("arst_pc",    id_pc_o, 64'(0));
        chk("arst_ready", 64'(if_ready_o), 64'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, B, 0);
        check_model("post_arst");
        chk("post_arst_pc", id_pc_o, B);

        // random traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic [63:0] rp;
            rp = {$urandom, $urandom};
            step(($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)), rp, 1'($urandom_range(0, 1)));
            check_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
